// File: rtl/riscv_pkg.sv
// Shared RV32I decode definitions: opcodes, ALU/immediate selectors and the
// control bundle carried from ID to EX.
package riscv_pkg;

    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam int ID_CTRL_W = 16;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR,
        ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_PASSB
    } alu_op_e;

    typedef enum logic [2:0] {
        IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J
    } imm_type_e;

    // wb_sel: 0 = ALU result, 1 = load data, 2 = PC+4
    typedef struct packed {
        alu_op_e     alu_op;
        logic        alu_src_imm;
        logic        mem_read;
        logic        mem_write;
        logic        reg_write;
        logic [1:0]  wb_sel;
        logic        is_branch;
        logic        is_jal;
        logic        is_jalr;
        logic [2:0]  funct3;
    } id_ctrl_t;

endpackage

// File: rtl/imm_gen.sv
// Immediate generator: extracts and sign-extends the I/S/B/U/J immediate.
// The opcode bits are not needed here, so only instr[31:7] is taken.
module imm_gen
    import riscv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:7]     instr_i,
    input  imm_type_e       imm_type_i,
    output logic [XLEN-1:0] imm_o
);

    logic signed [31:0] imm32;

    always_comb begin
        imm32 = '0;
        unique case (imm_type_i)
            IMM_I: imm32 = {{20{instr_i[31]}}, instr_i[31:20]};
            IMM_S: imm32 = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
            IMM_B: imm32 = {{20{instr_i[31]}}, instr_i[7], instr_i[30:25],
                            instr_i[11:8], 1'b0};
            IMM_U: imm32 = {instr_i[31:12], 12'b0};
            IMM_J: imm32 = {{12{instr_i[31]}}, instr_i[19:12], instr_i[20],
                            instr_i[30:21], 1'b0};
            default: imm32 = '0;
        endcase
        imm_o = XLEN'(imm32);
    end

endmodule

// File: rtl/decode_stage.sv
// RISC-V ID stage: decode, WB bypass, load-use stall, static branch
// prediction, and the ID/EX pipeline register.
module decode_stage
    import riscv_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter bit BTFN_EN = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            id_valid,
    input  logic [31:0]     id_instr,
    input  logic [XLEN-1:0] id_pc,
    output logic [4:0]      rf_a1,
    output logic [4:0]      rf_a2,
    input  logic [XLEN-1:0] rf_rd1,
    input  logic [XLEN-1:0] rf_rd2,
    input  logic            wb_we,
    input  logic [4:0]      wb_a3,
    input  logic [XLEN-1:0] wb_wd3,
    input  logic            flush,
    output logic            stall_o,
    output logic            pred_taken_o,
    output logic [XLEN-1:0] pred_target_o,
    output logic            ex_valid,
    output logic [XLEN-1:0] ex_pc,
    output logic [XLEN-1:0] ex_rs1_val,
    output logic [XLEN-1:0] ex_rs2_val,
    output logic [XLEN-1:0] ex_imm,
    output logic [4:0]      ex_rs1,
    output logic [4:0]      ex_rs2,
    output logic [4:0]      ex_rd,
    output id_ctrl_t        ex_ctrl,
    output logic            ex_pred_taken,
    output logic            ex_illegal
);

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] rs1_val;
        logic [XLEN-1:0] rs2_val;
        logic [XLEN-1:0] imm;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        id_ctrl_t        ctrl;
        logic            pred_taken;
        logic            illegal;
    } id_ex_t;

    function automatic alu_op_e alu_fn(input logic [2:0] f3, input logic f7b, input logic is_r);
        unique case (f3)
            3'b000:  return (is_r && f7b) ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return f7b ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    logic [6:0]      opcode;
    logic [4:0]      rs1, rs2, rd;
    id_ctrl_t        ctrl;
    imm_type_e       imm_type;
    logic            illegal, uses_rs1, uses_rs2;
    logic [XLEN-1:0] imm, rs1_val, rs2_val;
    logic            load_use, go;
    id_ex_t          ex_d, ex_q;

    assign opcode = id_instr[6:0];
    assign rd     = id_instr[11:7];
    assign rs1    = id_instr[19:15];
    assign rs2    = id_instr[24:20];
    assign rf_a1  = rs1;
    assign rf_a2  = rs2;

    always_comb begin
        ctrl        = '0;
        ctrl.funct3 = id_instr[14:12];
        imm_type    = IMM_NONE;
        illegal     = 1'b0;
        uses_rs1    = 1'b1;
        uses_rs2    = 1'b0;
        unique case (opcode)
            OPC_R: begin
                ctrl.alu_op = alu_fn(id_instr[14:12], id_instr[30], 1'b1);
                ctrl.reg_write = 1'b1;
                uses_rs2 = 1'b1;
            end
            OPC_OPIMM: begin
                ctrl.alu_op = alu_fn(id_instr[14:12], id_instr[30], 1'b0);
                ctrl.alu_src_imm = 1'b1;
                ctrl.reg_write = 1'b1;
                imm_type = IMM_I;
            end
            OPC_LOAD: begin
                ctrl.alu_src_imm = 1'b1;
                ctrl.mem_read = 1'b1;
                ctrl.reg_write = 1'b1;
                ctrl.wb_sel = 2'd1;
                imm_type = IMM_I;
            end
            OPC_STORE: begin
                ctrl.alu_src_imm = 1'b1;
                ctrl.mem_write = 1'b1;
                imm_type = IMM_S;
                uses_rs2 = 1'b1;
            end
            OPC_BRANCH: begin
                ctrl.alu_op = ALU_SUB;
                ctrl.is_branch = 1'b1;
                imm_type = IMM_B;
                uses_rs2 = 1'b1;
            end
            OPC_JAL: begin
                ctrl.reg_write = 1'b1;
                ctrl.wb_sel = 2'd2;
                ctrl.is_jal = 1'b1;
                imm_type = IMM_J;
                uses_rs1 = 1'b0;
            end
            OPC_JALR: begin
                ctrl.alu_src_imm = 1'b1;
                ctrl.reg_write = 1'b1;
                ctrl.wb_sel = 2'd2;
                ctrl.is_jalr = 1'b1;
                imm_type = IMM_I;
            end
            OPC_LUI: begin
                ctrl.alu_op = ALU_PASSB;
                ctrl.alu_src_imm = 1'b1;
                ctrl.reg_write = 1'b1;
                imm_type = IMM_U;
                uses_rs1 = 1'b0;
            end
            OPC_AUIPC: begin
                ctrl.alu_src_imm = 1'b1;
                ctrl.reg_write = 1'b1;
                imm_type = IMM_U;
                uses_rs1 = 1'b0;
            end
            default: illegal = 1'b1;
        endcase
        if (rd == 5'd0) ctrl.reg_write = 1'b0;
    end

    imm_gen #(.XLEN(XLEN)) u_imm_gen (
        .instr_i    (id_instr[31:7]),
        .imm_type_i (imm_type),
        .imm_o      (imm)
    );

    // Register file writes on the edge but reads are asynchronous, so a
    // same-cycle writeback to a source register must be forwarded here.
    assign rs1_val = (wb_we && wb_a3 != 5'd0 && wb_a3 == rs1) ? wb_wd3 : rf_rd1;
    assign rs2_val = (wb_we && wb_a3 != 5'd0 && wb_a3 == rs2) ? wb_wd3 : rf_rd2;

    assign load_use = id_valid && ex_q.valid && ex_q.ctrl.mem_read && ex_q.rd != 5'd0 &&
                      ((uses_rs1 && rs1 == ex_q.rd) || (uses_rs2 && rs2 == ex_q.rd));
    assign stall_o  = load_use && !flush;
    assign go       = id_valid && !stall_o && !flush && !rst;

    assign pred_taken_o  = go && (ctrl.is_jal || (ctrl.is_branch && BTFN_EN && imm[XLEN-1]));
    assign pred_target_o = id_valid ? id_pc + imm : '0;

    // Flush, stall and idle all load an all-zero bubble; only go captures.
    always_comb begin
        ex_d = '0;
        if (go) begin
            ex_d.valid      = 1'b1;
            ex_d.pc         = id_pc;
            ex_d.rs1_val    = rs1_val;
            ex_d.rs2_val    = rs2_val;
            ex_d.imm        = imm;
            ex_d.rs1        = rs1;
            ex_d.rs2        = rs2;
            ex_d.rd         = rd;
            ex_d.ctrl       = ctrl;
            ex_d.pred_taken = pred_taken_o;
            ex_d.illegal    = illegal;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) ex_q <= '0;
        else     ex_q <= ex_d;
    end

    assign ex_valid      = ex_q.valid;
    assign ex_pc         = ex_q.pc;
    assign ex_rs1_val    = ex_q.rs1_val;
    assign ex_rs2_val    = ex_q.rs2_val;
    assign ex_imm        = ex_q.imm;
    assign ex_rs1        = ex_q.rs1;
    assign ex_rs2        = ex_q.rs2;
    assign ex_rd         = ex_q.rd;
    assign ex_ctrl       = ex_q.ctrl;
    assign ex_pred_taken = ex_q.pred_taken;
    assign ex_illegal    = ex_q.illegal;

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Instruction Decode (ID) stage of the 5-stage RISC-V pipeline, directly downstream of IF/ID and wrapped around the register file.
- Drives register file read addresses and takes its read data.
- Decodes the instruction, generates the immediate, and bypasses same-cycle writeback data.
- Detects load-use hazards, makes the static branch prediction, and owns the ID/EX pipeline register consumed by EX.

Parameters:
- XLEN, 32, datapath and PC width.
- BTFN_EN, 1, 1 = backward-taken/forward-not-taken prediction; 0 = predict all branches not-taken (JAL still predicted taken).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- id_valid  in  1  IF/ID holds a valid instruction
- id_instr  in  32  instruction word
- id_pc  in  XLEN  instruction PC
- rf_a1  out  5  register file read address 1 (= instr[19:15])
- rf_a2  out  5  register file read address 2 (= instr[24:20])
- rf_rd1  in  XLEN  register file read data 1
- rf_rd2  in  XLEN  register file read data 2
- wb_we  in  1  writeback write enable (same signal as register file write enable)
- wb_a3  in  5  writeback destination register
- wb_wd3  in  XLEN  writeback data
- flush  in  1  EX misprediction/redirect; kill ID contents
- stall_o  out  1  hold PC and IF/ID this cycle
- pred_taken_o  out  1  redirect IF to pred_target_o
- pred_target_o  out  XLEN  predicted target (id_pc + imm)
- ex_valid  out  1  ID/EX valid
- ex_pc, ex_rs1_val, ex_rs2_val, ex_imm  out  XLEN each  ID/EX datapath
- ex_rs1, ex_rs2, ex_rd  out  5 each  register indices for forwarding
- ex_ctrl  out  16  id_ctrl_t control bundle
- ex_pred_taken  out  1  prediction made, for EX comparison
- ex_illegal  out  1  unknown opcode flag

Behaviour:
- Reset: all ex_* registers are cleared to 0 (ex_valid = 0). stall_o, pred_taken_o and pred_target_o are combinational and are 0 while ex_valid = 0 and id_valid = 0.
- Opcodes decoded: R 0110011, OP-IMM 0010011, LOAD 0000011, STORE 0100011, BRANCH 1100011, JAL 1101111, JALR 1100111, LUI 0110111, AUIPC 0010111.
- Any other opcode: ex_illegal = 1, and mem_write and reg_write are forced to 0.
- Immediates: I, S, B, U and J formats, sign-extended from instr[31].
- uses_rs1: all opcodes except LUI, AUIPC and JAL. uses_rs2: R, STORE and BRANCH.
- rd = 0 forces reg_write = 0.
- WB bypass:
  - rs1_val = wb_wd3 if (wb_we && wb_a3 != 0 && wb_a3 == rs1), else rf_rd1. rs2 is handled the same way.
  - Required because the register file writes at the clock edge while reads are asynchronous.
- Load-use stall:
  - load_use = id_valid && ex_valid && ex_ctrl.mem_read && ex_rd != 0 && ((uses_rs1 && rs1 == ex_rd) || (uses_rs2 && rs2 == ex_rd)).
  - stall_o = load_use && !flush.
  - On stall, ID/EX loads a bubble (ex_valid = 0, ex_ctrl = 0) and the instruction is re-decoded next cycle. Stall lasts exactly 1 cycle.
- Prediction (valid only when go = id_valid && !stall_o && !flush):
  - JAL is always predicted taken.
  - BRANCH is predicted taken iff BTFN_EN && imm[XLEN-1] == 1.
  - JALR is never predicted.
  - pred_target_o = id_pc + imm, mod 2^XLEN (wraps).
  - pred_taken_o is combinational; IF redirects on the next edge.
- Pipeline register, 1-cycle latency, priority rst > flush > stall > go:
  - flush: ex_valid <= 0; pred_taken_o and stall_o are forced to 0.
  - go: ex_* <= decoded values, ex_pred_taken <= pred_taken_o.
  - id_valid = 0: ex_valid <= 0.
- Simultaneous flush and load_use: flush wins, with no stall.
- Reset mid-stall: ex cleared, stall_o = 0 the following cycle.
- id_ctrl_t field order, MSB→LSB: alu_op[3:0], alu_src_imm, mem_read, mem_write, reg_write, wb_sel[1:0] (0 ALU, 1 MEM, 2 PC+4), is_branch, is_jal, is_jalr, funct3[2:0].

Decomposition:
- riscv_pkg holds: opcode localparams, alu_op_e, imm_type_e, the id_ctrl_t packed struct, and ID_CTRL_W = 16.
- One sub-module, imm_gen: purely combinational instr plus imm_type_e → XLEN immediate.
- Decode, hazard detection and prediction live in decode_stage.

Test Plan:
- Reset asserted 2 cycles with id_valid = 1 → ex_valid = 0, stall_o = 0, pred_taken_o = 0. The first edge after release captures the instruction.
- addi x5,x0,-1 (0xFFF00293) at pc 0x100 → next cycle ex_imm = 0xFFFFFFFF, ex_rd = 5, reg_write = 1, alu_src_imm = 1, ex_pc = 0x100.
- lw x6,0(x1) then add x7,x6,x2:
  - stall_o = 1 for 1 cycle and ex_valid = 0 bubble.
  - The add is issued the cycle after.
  - lw then add x7,x0,x2 → no stall.
- WB bypass: wb_we = 1, wb_a3 = 3, wb_wd3 = 0xDEADBEEF, rf_rd1 = 4, decode add x8,x3,x3 → ex_rs1_val = ex_rs2_val = 0xDEADBEEF. Same stimulus with wb_a3 = 0 → values = rf_rd1/rf_rd2.
- Prediction:
  - beq at pc 0x200 with imm -8 → pred_taken_o = 1, target 0x1F8.
  - imm +16 → not taken.
  - jal at 0xFFFFFFFC with imm +8 → taken, target 0x4 (wrap).
  - BTFN_EN = 0 with imm -8 → not taken.
- flush together with load_use and a backward branch → stall_o = 0, pred_taken_o = 0, next ex_valid = 0.
